// File: rtl/mlaccel_seqv2_if.sv
// mlaccel_seqv2_if: sequencer-memory fetch bus and compute-core command bus.
// The master side is the sequencer; the slave side is memory plus compute core.
interface mlaccel_seqv2_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  smem_valid;
    logic                  smem_ready;
    logic [ADDR_WIDTH-1:0] smem_addr;
    logic [31:0]           smem_data;
    logic                  comp_valid;
    logic                  comp_ready;
    logic [31:0]           comp_data;

    modport master (
        output smem_valid, smem_addr, comp_valid, comp_data,
        input  smem_ready, smem_data, comp_ready
    );

    modport slave (
        input  smem_valid, smem_addr, comp_valid, comp_data,
        output smem_ready, smem_data, comp_ready
    );
endinterface

// File: rtl/mlaccel_seqv2.sv
// mlaccel_seqv2: instruction sequencer with hardware call/return stack and command FIFO.
// Define MLACCEL_SEQ_EXPAND_EN to expand multi-step EXECUTE instructions into per-step commands.
module mlaccel_seqv2 #(
    parameter int ADDR_WIDTH = 16,
    parameter int QUEUE_LOG2 = 9,
    parameter int STACK_LOG2 = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  busy,
    output logic                  error,
    mlaccel_seqv2_if.master       bus
);
    localparam int QDEPTH = 2 ** QUEUE_LOG2;
    localparam logic [QUEUE_LOG2:0] THRESH = (QUEUE_LOG2 + 1)'(QDEPTH - 2);
    localparam logic [5:0] OP_CALL   = 6'd1;
    localparam logic [5:0] OP_RETURN = 6'd2;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT_SPACE} state_t;

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_next, w_pc_inc;
    logic                  r_smem_valid, w_smem_valid_next;
    logic                  r_error, w_error_next;
    logic                  r_busy;
    logic [5:0]            w_op;

    logic [ADDR_WIDTH-1:0] r_stack [2 ** STACK_LOG2];
    logic [STACK_LOG2:0]   r_sp, w_sp_dec;
    logic                  w_push, w_pop, w_stack_full, w_stack_empty;

    logic [31:0]           r_fifo [QDEPTH];
    logic [QUEUE_LOG2-1:0] r_wptr, r_rptr;
    logic [QUEUE_LOG2:0]   r_count, w_count_next;
    logic                  r_thresh, w_fifo_wr, w_fifo_rd, w_fifo_empty;

    logic                  r_rd_valid, w_rd_free;
    logic [31:0]           r_rd_data;
    logic                  r_comp_valid, w_out_adv, w_src_valid;
    logic [31:0]           r_comp_data, w_src_data;

    assign w_op          = bus.smem_data[5:0];
    assign w_pc_inc      = r_pc + ADDR_WIDTH'(1);
    assign w_stack_full  = r_sp[STACK_LOG2];
    assign w_stack_empty = (r_sp == '0);
    assign w_sp_dec      = r_sp - (STACK_LOG2 + 1)'(1);

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_smem_valid_next = r_smem_valid;
        w_error_next      = r_error;
        w_push            = 1'b0;
        w_pop             = 1'b0;
        w_fifo_wr         = 1'b0;
        if (start) begin
            w_state_next      = S_FETCH;
            w_pc_next         = addr;
            w_smem_valid_next = 1'b1;
            w_error_next      = 1'b0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (!r_smem_valid) begin
                        if (r_thresh) w_state_next = S_WAIT_SPACE;
                        else          w_smem_valid_next = 1'b1;
                    end else if (bus.smem_ready) begin
                        w_smem_valid_next = 1'b0;
                        if (w_op == OP_CALL) begin
                            if (w_stack_full) begin
                                w_error_next = 1'b1;
                                w_state_next = S_IDLE;
                            end else begin
                                w_push    = 1'b1;
                                w_pc_next = bus.smem_data[31 -: ADDR_WIDTH];
                            end
                        end else if (w_op == OP_RETURN) begin
                            if (w_stack_empty) begin
                                w_state_next = S_IDLE;
                            end else begin
                                w_pop     = 1'b1;
                                w_pc_next = r_stack[w_sp_dec[STACK_LOG2-1:0]];
                            end
                        end else begin
                            w_fifo_wr = 1'b1;
                            w_pc_next = w_pc_inc;
                        end
                    end
                end
                S_WAIT_SPACE: begin
                    if (!r_thresh) begin
                        w_state_next      = S_FETCH;
                        w_smem_valid_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_smem_valid <= 1'b0;
            r_error      <= 1'b0;
            r_busy       <= 1'b0;
            r_sp         <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_smem_valid <= w_smem_valid_next;
            r_error      <= w_error_next;
            r_busy       <= start || (r_state != S_IDLE) || !w_fifo_empty;
            if (start)       r_sp <= '0;
            else if (w_push) r_sp <= r_sp + (STACK_LOG2 + 1)'(1);
            else if (w_pop)  r_sp <= w_sp_dec;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_stack[r_sp[STACK_LOG2-1:0]] <= w_pc_inc;
    end

    // Threshold is registered from next occupancy, so it always matches the current count.
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_rd    = w_rd_free && !w_fifo_empty;
    assign w_count_next = r_count + (QUEUE_LOG2 + 1)'(w_fifo_wr) - (QUEUE_LOG2 + 1)'(w_fifo_rd);

    always_ff @(posedge clock) begin
        if (reset || start) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_thresh <= 1'b0;
        end else begin
            if (w_fifo_wr) r_wptr <= r_wptr + QUEUE_LOG2'(1);
            if (w_fifo_rd) r_rptr <= r_rptr + QUEUE_LOG2'(1);
            r_count  <= w_count_next;
            r_thresh <= (w_count_next >= THRESH);
        end
    end

    always_ff @(posedge clock) begin
        if (w_fifo_wr) r_fifo[r_wptr] <= bus.smem_data;
    end

    always_ff @(posedge clock) begin
        if (reset || start) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (w_rd_free) begin
            r_rd_valid <= !w_fifo_empty;
            r_rd_data  <= r_fifo[r_rptr];
        end
    end

    assign w_out_adv = !r_comp_valid || bus.comp_ready;

`ifdef MLACCEL_SEQ_EXPAND_EN
    localparam logic [5:0] OP_EXECUTE = 6'd3;

    logic        r_ex_valid, w_ex_more, w_ex_free;
    logic [31:0] r_ex_data;
    logic [14:0] w_ex_count;
    logic [10:0] w_ex_base;

    // The expansion register holds the command about to issue; it steps in place until count reaches 1.
    assign w_ex_count  = r_ex_data[31:17];
    assign w_ex_base   = r_ex_data[16:6];
    assign w_ex_more   = (r_ex_data[5:0] == OP_EXECUTE) && (w_ex_count >= 15'd2);
    assign w_ex_free   = !r_ex_valid || (w_out_adv && !w_ex_more);
    assign w_rd_free   = !r_rd_valid || w_ex_free;
    assign w_src_valid = r_ex_valid;
    assign w_src_data  = r_ex_data;

    always_ff @(posedge clock) begin
        if (reset || start) begin
            r_ex_valid <= 1'b0;
            r_ex_data  <= '0;
        end else if (w_ex_free) begin
            r_ex_valid <= r_rd_valid;
            r_ex_data  <= r_rd_data;
        end else if (w_out_adv) begin
            r_ex_data <= {w_ex_count - 15'd1, w_ex_base + 11'd1, r_ex_data[5:0]};
        end
    end
`else
    assign w_rd_free   = !r_rd_valid || w_out_adv;
    assign w_src_valid = r_rd_valid;
    assign w_src_data  = r_rd_data;
`endif

    // A command already in the output register survives start; nothing new loads on that edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_comp_valid <= 1'b0;
            r_comp_data  <= '0;
        end else if (w_out_adv) begin
            r_comp_valid <= w_src_valid && !start;
            if (w_src_valid && !start) r_comp_data <= w_src_data;
        end
    end

    assign bus.smem_valid = r_smem_valid;
    assign bus.smem_addr  = r_pc;
    assign bus.comp_valid = r_comp_valid;
    assign bus.comp_data  = r_comp_data;
    assign busy           = r_busy;
    assign error          = r_error;
endmodule

// File: tb/tb_mlaccel_seqv2.sv
// tb_mlaccel_seqv2: randomized program runs checked against a program-level sequencer model.
module tb_mlaccel_seqv2;
    localparam int AW     = 16;
    localparam int QL     = 3;
    localparam int SL     = 1;
    localparam int QDEPTH = 2 ** QL;
    localparam int SDEPTH = 2 ** SL;
`ifdef MLACCEL_SEQ_EXPAND_EN
    localparam bit EXPAND = 1'b1;
    localparam int PIPE   = 3;
`else
    localparam bit EXPAND = 1'b0;
    localparam int PIPE   = 2;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] addr;
    logic          busy;
    logic          error;

    mlaccel_seqv2_if #(.ADDR_WIDTH(AW)) bus ();

    mlaccel_seqv2 #(.ADDR_WIDTH(AW), .QUEUE_LOG2(QL), .STACK_LOG2(SL)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .addr  (addr),
        .busy  (busy),
        .error (error),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [31:0]   mem [0:65535];
    logic [AW-1:0] fetch_log [$];
    logic [31:0]   cmd_log [$];
    logic [AW-1:0] exp_fetch [$];
    logic [31:0]   exp_cmd [$];
    logic          exp_err;
    int            rdy_mode = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Program-level reference: walks the program and lists fetch addresses and emitted commands.
    function automatic void run_model(input logic [AW-1:0] a);
        logic [AW-1:0] pc;
        logic [AW-1:0] stk [$];
        logic [31:0]   w;
        int            c;
        pc = a;
        exp_fetch.delete();
        exp_cmd.delete();
        exp_err = 1'b0;
        for (int n = 0; n < 500; n++) begin
            w = mem[pc];
            exp_fetch.push_back(pc);
            if (w[5:0] == 6'd1) begin
                if (stk.size() == SDEPTH) begin
                    exp_err = 1'b1;
                    return;
                end
                stk.push_back(pc + 16'd1);
                pc = w[31:16];
            end else if (w[5:0] == 6'd2) begin
                if (stk.size() == 0) return;
                pc = stk.pop_back();
            end else begin
                c = int'(w[31:17]);
                if (EXPAND && w[5:0] == 6'd3 && c >= 2) begin
                    for (int k = 0; k < c; k++)
                        exp_cmd.push_back({15'(c - k), 11'(int'(w[16:6]) + k), w[5:0]});
                end else begin
                    exp_cmd.push_back(w);
                end
                pc = pc + 16'd1;
            end
        end
    endfunction

    function automatic logic [31:0] plain_word();
        logic [31:0] w;
        w = $urandom();
        w[5:0] = 6'($urandom_range(4, 63));
        return w;
    endfunction

    function automatic logic [31:0] mk_call(input logic [AW-1:0] t);
        return {t, 10'h000, 6'd1};
    endfunction

    function automatic logic [31:0] mk_exec(input int cnt, input logic [10:0] base);
        return {15'(cnt), base, 6'd3};
    endfunction

    // Memory responder and command sink; decisions are made mid-cycle for the coming edge.
    bit          hold_pend = 1'b0;
    logic [31:0] hold_data = '0;
    initial begin
        bit r;
        bit sr;
        bus.smem_ready = 1'b0;
        bus.smem_data  = '0;
        bus.comp_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (hold_pend && !reset) begin
                check_eq("hold_valid", 32'(bus.comp_valid), 32'd1);
                check_eq("hold_data", bus.comp_data, hold_data);
            end
            case (rdy_mode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.comp_ready = r;
            if (!reset && bus.comp_valid === 1'b1 && r) cmd_log.push_back(bus.comp_data);
            hold_pend = !reset && (bus.comp_valid === 1'b1) && !r;
            hold_data = bus.comp_data;
            sr = (bus.smem_valid === 1'b1) && ($urandom_range(0, 3) != 0);
            bus.smem_ready = sr;
            bus.smem_data  = mem[bus.smem_addr];
            if (!reset && !start && sr) fetch_log.push_back(bus.smem_addr);
        end
    end

    task automatic run_prog(input logic [AW-1:0] a, input int mode, input int stall,
                            input bit left_ok, input logic [31:0] left_word);
        int t;
        run_model(a);
        @(posedge clock);
        #1;
        start = 1'b1;
        addr  = a;
        fetch_log.delete();
        cmd_log.delete();
        rdy_mode = (stall > 0) ? 0 : mode;
        @(posedge clock);
        #1;
        start = 1'b0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_err_clr", 32'(error), 32'd0);
        check_eq("first_valid", 32'(bus.smem_valid), 32'd1);
        check_eq("first_addr", 32'(bus.smem_addr), 32'(a));
        if (stall > 0) begin
            repeat (stall) @(posedge clock);
            #1;
            check_eq("stall_fetches", fetch_log.size(), QDEPTH - 2 + PIPE);
            check_eq("stall_cmds", cmd_log.size(), 0);
            rdy_mode = mode;
        end
        t = 0;
        while (busy && t < 5000) begin
            @(posedge clock);
            #1;
            t++;
        end
        check_eq("busy_fall", 32'(busy), 32'd0);
        rdy_mode = 1;
        repeat (20) @(posedge clock);
        #1;
        check_eq("drained", 32'(bus.comp_valid), 32'd0);
        check_eq("idle_fetch", 32'(bus.smem_valid), 32'd0);
        check_eq("error", 32'(error), 32'(exp_err));
        check_eq("fetch_n", fetch_log.size(), exp_fetch.size());
        for (int i = 0; i < fetch_log.size() && i < exp_fetch.size(); i++)
            check_eq($sformatf("fetch[%0d]", i), 32'(fetch_log[i]), 32'(exp_fetch[i]));
        if (left_ok && cmd_log.size() == exp_cmd.size() + 1) begin
            check_eq("held_cmd", cmd_log[0], left_word);
            void'(cmd_log.pop_front());
        end
        check_eq("cmd_n", cmd_log.size(), exp_cmd.size());
        for (int i = 0; i < cmd_log.size() && i < exp_cmd.size(); i++)
            check_eq($sformatf("cmd[%0d]", i), cmd_log[i], exp_cmd[i]);
    endtask

    initial begin
        logic [31:0] old_first;
        for (int i = 0; i < 65536; i++) mem[i] = 32'd2;

        for (int i = 0; i < 4; i++) mem[16'h0010 + i] = plain_word();
        mem[16'h0014] = 32'd2;

        mem[16'h0020] = plain_word();
        mem[16'h0021] = mk_call(16'h0100);
        mem[16'h0022] = plain_word();
        mem[16'h0023] = 32'd2;
        mem[16'h0100] = plain_word();
        mem[16'h0101] = mk_call(16'h0200);
        mem[16'h0102] = plain_word();
        mem[16'h0103] = 32'd2;
        mem[16'h0200] = plain_word();
        mem[16'h0201] = plain_word();
        mem[16'h0202] = 32'd2;

        mem[16'h0030] = mk_call(16'h0400);
        mem[16'h0400] = plain_word();
        mem[16'h0401] = mk_call(16'h0500);
        mem[16'h0500] = mk_call(16'h0600);
        mem[16'h0600] = plain_word();

        mem[16'h0040] = mk_exec(3, 11'h7FE);
        mem[16'h0041] = mk_exec(1, 11'h123);
        mem[16'h0042] = mk_exec(0, 11'h456);
        mem[16'h0043] = plain_word();
        mem[16'h0044] = 32'd2;

        for (int i = 0; i < 30; i++) mem[16'h2000 + i] = plain_word();
        mem[16'h201E] = 32'd2;

        for (int i = 0; i < 40; i++) mem[16'h3000 + i] = plain_word();
        mem[16'h3028] = 32'd2;
        old_first = mem[16'h3000];
        for (int i = 0; i < 5; i++) mem[16'h0300 + i] = plain_word();
        mem[16'h0305] = 32'd2;

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) begin
                case ($urandom_range(0, 4))
                    0:       mem[16'h5000 + 16'(r * 256 + i)] = mk_exec($urandom_range(0, 4), 11'($urandom()));
                    1:       mem[16'h5000 + 16'(r * 256 + i)] = {26'($urandom()), 6'd0};
                    default: mem[16'h5000 + 16'(r * 256 + i)] = plain_word();
                endcase
            end
        end

        reset = 1'b1;
        start = 1'b0;
        addr  = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_smem_valid", 32'(bus.smem_valid), 32'd0);
        check_eq("rst_smem_addr", 32'(bus.smem_addr), 32'd0);
        check_eq("rst_comp_valid", 32'(bus.comp_valid), 32'd0);
        check_eq("rst_comp_data", bus.comp_data, 32'd0);
        reset = 1'b0;

        run_prog(16'h0010, 1, 0, 1'b0, '0);
        run_prog(16'h0020, 2, 0, 1'b0, '0);
        run_prog(16'h0030, 1, 0, 1'b0, '0);
        run_prog(16'h0040, 1, 0, 1'b0, '0);
        run_prog(16'h2000, 1, 50, 1'b0, '0);

        @(posedge clock);
        #1;
        start    = 1'b1;
        addr     = 16'h3000;
        rdy_mode = 0;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check_eq("pre_restart_busy", 32'(busy), 32'd1);
        run_prog(16'h0300, 2, 0, 1'b1, old_first);

        for (int r = 0; r < 3; r++) run_prog(16'h5000 + 16'(r * 256), 2, 0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mlaccel_seqv2.md
# mlaccel_seqv2

Second-generation instruction sequencer for the ML accelerator. It fetches 32-bit instruction words from sequencer memory and resolves call/return in hardware against a parametrised return stack. Non-control instructions are buffered in a parametrised FIFO, and EXECUTE instructions are optionally expanded into per-step compute commands. It sits between the host start/addr register and the compute core's instruction port, and adds stack-overflow detection and an error output.

## Interface
- ADDR_WIDTH, 16: smem word-address width; PC width.
- QUEUE_LOG2, 9: FIFO depth = 2**QUEUE_LOG2 entries (min 3).
- STACK_LOG2, 9: return stack depth = 2**STACK_LOG2 entries (min 1).
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clock.
- start  in  1  one-cycle pulse; (re)start at addr.
- addr  in  ADDR_WIDTH  entry word address.
- busy  out  1  registered; running, FIFO non-empty, or start seen this cycle.
- error  out  1  sticky stack-overflow flag; cleared by reset/start.
- smem_valid  out  1  fetch request.
- smem_ready  in  1  fetch response; smem_data valid same cycle.
- smem_addr  out  ADDR_WIDTH  fetch word address.
- smem_data  in  32  fetched instruction.
- comp_valid  out  1  command valid.
- comp_ready  in  1  core accepts command.
- comp_data  out  32  command word.

## Operation
- Opcode = insn[5:0]. SYNC=0, CALL=1, RETURN=2, EXECUTE=3. All other opcodes are forwarded unchanged.
- Front-end states: IDLE, FETCH (smem_valid high), WAIT_SPACE (FIFO at threshold). At most one outstanding fetch.
- CALL: push pc+1 and set pc = insn[31:32-ADDR_WIDTH]. If the stack already holds 2**STACK_LOG2 entries, set error=1, enter IDLE, and push nothing.
- RETURN: pop into pc if the stack is non-empty. With an empty stack, enter IDLE (normal end of program).
- Other opcodes: write to FIFO, pc = pc+1 (wraps modulo 2**ADDR_WIDTH).
- CALL/RETURN never enter the FIFO.
- FIFO threshold: no new fetch is issued while occupancy >= 2**QUEUE_LOG2 - 2 (registered compare). The FIFO never overflows.
- Back-end: a FIFO read register feeds an expansion register, which feeds the comp output register.
- comp_data/comp_valid update only when !comp_valid || comp_ready. Data is held stable while stalled.
- EXECUTE fields: count = insn[31:17], base = insn[16:6].
- With expansion, count c >= 2 produces c commands. The k-th command (k=0..c-1) carries count c-k and base base+k (11-bit wrap). Opcode and other bits are unchanged. The FIFO is not read until the last command (count 1) is issued.
- count 0 or 1 is forwarded once, unchanged.
- Commands leave in program order; no command is dropped or duplicated under backpressure.
- start (when not in reset) performs all of the following:
  - pc = addr; stack and FIFO are flushed.
  - Any outstanding fetch is abandoned and a response in the same cycle is ignored.
  - Expansion state is cleared; error=0; the front-end enters FETCH.
  - comp_valid is NOT forcibly dropped: a held command completes its handshake.
- reset has priority over start.

## Timing
- Reset values: busy=0, error=0, smem_valid=0, smem_addr=0, comp_valid=0, comp_data=0.
- Fetch path:
  - smem_valid rises on the cycle after start, with smem_addr=addr.
  - After each smem_ready, smem_valid is low for exactly one cycle before the next request.
  - The next request carries the updated pc (after call, return, or increment).
- Forwarding latency: a word accepted at edge t from an empty FIFO, with comp_ready held high, shows comp_valid=1 after edge t+3.
- Expansion throughput: one command per cycle while comp_ready is high.
- busy is high after the edge where start is sampled. It drops one cycle after running=0 and the FIFO empties; it does not wait for the expansion/output registers to drain.
- error asserts on the cycle after the overflowing CALL response.

## Configuration
- MLACCEL_SEQ_EXPAND_EN defined: EXECUTE expansion as described above.
- Not defined: the expansion register is removed; EXECUTE is forwarded once, unchanged, like any other opcode. Forwarding latency becomes t+2.

## Test plan
- Straight-line program:
  - Stimulus: 4 non-control words at 0x0010, RETURN at 0x0014; start addr=0x0010, comp_ready=1.
  - Response: 4 commands in order, busy falls, error=0.
- Nested calls:
  - Stimulus: CALL 0x0100 → CALL 0x0200 → RETURN → RETURN with STACK_LOG2=2.
  - Response: correct fetch address sequence; only non-control words appear on comp.
- Stack overflow:
  - Stimulus: STACK_LOG2=1 and three nested CALLs.
  - Response: error=1 after the 3rd CALL response, no further fetches, busy drops after drain.
- Expansion:
  - Stimulus: EXECUTE with count=3, base=0x7FE.
  - Response: commands with (count, base) = (3, 0x7FE), (2, 0x7FF), (1, 0x000). Without the macro: one unchanged command.
- Backpressure and full FIFO:
  - Stimulus: QUEUE_LOG2=3, comp_ready=0 for 50 cycles.
  - Response: FIFO stops fetching at occupancy 6, comp_data stays stable, and all commands emerge in order after release.
- Restart mid-run:
  - Stimulus: start addr=0x0300 while fetching and with the FIFO non-empty.
  - Response: old queued words are discarded; the first fetch after restart is 0x0300.
